// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the writable instruction memory.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_if.sv
// Boot-load and fetch bus between the fetch stage (master) and inst_mem (slave).
interface inst_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              load_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_err;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic              mem_ready;

    modport master (
        output load_en, prog_we, prog_addr, prog_data, fetch_req, fetch_addr, stall,
        input  prog_err, fetch_valid, fetch_data, fetch_fault, mem_ready
    );

    modport slave (
        input  load_en, prog_we, prog_addr, prog_data, fetch_req, fetch_addr, stall,
        output prog_err, fetch_valid, fetch_data, fetch_fault, mem_ready
    );
endinterface

// File: rtl/inst_mem_array.sv
// Storage: one write port, one registered read port; the read register doubles as fetch_data.
module inst_mem_array #(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       ADDR_W = 4,
    parameter int unsigned       DEPTH  = 16,
    parameter logic [DATA_W-1:0] NOP    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic              rnop_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on storage; contents are initialised by the CLEAR sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds unless re_i, which is how stall hold is realised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rnop_i ? NOP : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_mem.sv
// Writable instruction memory: self-clear after reset, boot-load port, registered fetch with stall hold.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       ADDR_W = 4,
    parameter int unsigned       DEPTH  = 16,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_DEFAULT)
) (
    input  logic       clk,
    input  logic       rst_n,
    inst_mem_if.slave  mem_if
);

    localparam int unsigned LAST_IDX = DEPTH - 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic              prog_err_q, prog_err_d;
    logic              mem_ready_q, mem_ready_d;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              arr_re;
    logic              arr_rnop;
    logic [DATA_W-1:0] arr_rdata;

    logic fetch_in_range;
    logic prog_in_range;

    assign fetch_in_range = 32'(mem_if.fetch_addr) < DEPTH;
    assign prog_in_range  = 32'(mem_if.prog_addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            prog_err_q    <= 1'b0;
            mem_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_fault_q <= fetch_fault_d;
            prog_err_q    <= prog_err_d;
            mem_ready_q   <= mem_ready_d;
        end
    end

    // Next state, write-port mux and fetch control; load_en beats stall beats fetch_req.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        fetch_valid_d = fetch_valid_q;
        fetch_fault_d = fetch_fault_q;
        prog_err_d    = 1'b0;
        arr_we        = 1'b0;
        arr_waddr     = mem_if.prog_addr;
        arr_wdata     = mem_if.prog_data;
        arr_re        = 1'b0;
        arr_rnop      = 1'b0;

        unique case (state_q)
            ST_CLEAR: begin
                arr_we        = 1'b1;
                arr_waddr     = clr_cnt_q;
                arr_wdata     = NOP;
                fetch_valid_d = 1'b0;
                if (clr_cnt_q == ADDR_W'(LAST_IDX)) begin
                    clr_cnt_d = '0;
                    state_d   = mem_if.load_en ? ST_LOAD : ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
            ST_LOAD: begin
                fetch_valid_d = 1'b0;
                fetch_fault_d = 1'b0;
                if (mem_if.prog_we) begin
                    arr_we     = prog_in_range;
                    prog_err_d = !prog_in_range;
                end
                if (!mem_if.load_en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mem_if.load_en) begin
                    state_d       = ST_LOAD;
                    fetch_valid_d = 1'b0;
                end else if (!mem_if.stall) begin
                    fetch_valid_d = mem_if.fetch_req;
                    fetch_fault_d = mem_if.fetch_req && !fetch_in_range;
                    arr_re        = mem_if.fetch_req;
                    arr_rnop      = !fetch_in_range;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        mem_ready_d = (state_d == ST_RUN);
    end

    inst_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NOP    (NOP)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (arr_we && rst_n),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .rnop_i  (arr_rnop),
        .raddr_i (mem_if.fetch_addr),
        .rdata_o (arr_rdata)
    );

    assign mem_if.fetch_valid = fetch_valid_q;
    assign mem_if.fetch_fault = fetch_fault_q;
    assign mem_if.fetch_data  = arr_rdata;
    assign mem_if.prog_err    = prog_err_q;
    assign mem_if.mem_ready   = mem_ready_q;

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: directed scenarios plus random traffic checked against a behavioural model.
module tb_inst_mem;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 12;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam int P_CLR  = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    inst_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NOP    (NOP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem_if (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what the outputs must show after each edge.
    int          phase;
    int          clr_left;
    logic [31:0] mmem [DEPTH];
    logic        e_valid, e_fault, e_err, e_ready, chk_data;
    logic [31:0] e_data;

    task automatic model_edge();
        if (!rst_n) begin
            phase    = P_CLR;
            clr_left = DEPTH;
            foreach (mmem[i]) mmem[i] = NOP;
            e_valid  = 1'b0;
            e_fault  = 1'b0;
            e_err    = 1'b0;
            e_data   = 32'h0;
            chk_data = 1'b1;
        end else begin
            e_err = 1'b0;
            case (phase)
                P_CLR: begin
                    e_valid  = 1'b0;
                    clr_left = clr_left - 1;
                    if (clr_left == 0) phase = bus.load_en ? P_LOAD : P_RUN;
                end
                P_RUN: begin
                    if (bus.load_en) begin
                        phase   = P_LOAD;
                        e_valid = 1'b0;
                    end else if (!bus.stall) begin
                        e_valid = bus.fetch_req;
                        if (bus.fetch_req) begin
                            if (int'(bus.fetch_addr) >= int'(DEPTH)) begin
                                e_fault = 1'b1;
                                e_data  = NOP;
                            end else begin
                                e_fault = 1'b0;
                                e_data  = mmem[bus.fetch_addr];
                            end
                        end
                    end
                end
                default: begin
                    e_valid = 1'b0;
                    if (bus.prog_we) begin
                        if (int'(bus.prog_addr) < int'(DEPTH)) mmem[bus.prog_addr] = bus.prog_data;
                        else e_err = 1'b1;
                    end
                    if (!bus.load_en) phase = P_RUN;
                end
            endcase
            chk_data = e_valid;
        end
        e_ready = (phase == P_RUN);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ":ready"}, 32'(bus.mem_ready),   32'(e_ready));
        check({tag, ":valid"}, 32'(bus.fetch_valid), 32'(e_valid));
        check({tag, ":err"},   32'(bus.prog_err),    32'(e_err));
        if (chk_data) begin
            check({tag, ":data"},  bus.fetch_data,        e_data);
            check({tag, ":fault"}, 32'(bus.fetch_fault), 32'(e_fault));
        end
    endtask

    task automatic idle_inputs();
        bus.load_en    = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.stall      = 1'b0;
    endtask

    task automatic fetch(input int addr, input string tag);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = ADDR_W'(addr);
        step(tag);
        bus.fetch_req  = 1'b0;
    endtask

    task automatic prog(input int addr, input logic [31:0] data, input string tag);
        bus.prog_we   = 1'b1;
        bus.prog_addr = ADDR_W'(addr);
        bus.prog_data = data;
        step(tag);
        bus.prog_we   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step("rst0");
        step("rst1");
        check("rst_data", bus.fetch_data, 32'h0);

        // Self-clear: mem_ready rises exactly after edge DEPTH.
        rst_n = 1'b1;
        repeat (DEPTH - 1) step("clr");
        check("clr_not_ready", 32'(bus.mem_ready), 32'h0);
        step("clr_last");
        check("clr_ready", 32'(bus.mem_ready), 32'h1);

        fetch(5, "nop5");
        check("nop5_val", bus.fetch_data, NOP);
        check("nop5_flt", 32'(bus.fetch_fault), 32'h0);
        step("idle");

        // Load two words; the second write coincides with load_en dropping.
        bus.load_en = 1'b1;
        step("ld_enter");
        prog(0, 32'h0061_1020, "ld_w0");
        bus.load_en = 1'b0;
        prog(1, 32'h0062_1022, "ld_w1");
        check("ld_exit_ready", 32'(bus.mem_ready), 32'h1);

        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 4'd0;
        step("bb0");
        check("bb0_val", bus.fetch_data, 32'h0061_1020);
        bus.fetch_addr = 4'd1;
        step("bb1");
        check("bb1_val", bus.fetch_data, 32'h0062_1022);

        // Stall hold with a different request pending.
        bus.fetch_addr = 4'd0;
        step("st_pre");
        bus.stall      = 1'b1;
        bus.fetch_addr = 4'd1;
        for (int i = 0; i < 3; i++) begin
            step("st_hold");
            check("st_hold_val", bus.fetch_data, 32'h0061_1020);
            check("st_hold_vld", 32'(bus.fetch_valid), 32'h1);
        end
        bus.stall = 1'b0;
        step("st_rel");
        check("st_rel_val", bus.fetch_data, 32'h0062_1022);
        bus.fetch_req = 1'b0;
        step("idle");

        // Out-of-range fetch and dropped writes.
        fetch(13, "oor");
        check("oor_data", bus.fetch_data, NOP);
        check("oor_flt", 32'(bus.fetch_fault), 32'h1);
        bus.load_en = 1'b1;
        step("oor_ld");
        prog(14, 32'hFFFF_FFFF, "bad14");
        check("bad14_err", 32'(bus.prog_err), 32'h1);
        prog(15, 32'hFFFF_FFFF, "bad15");
        check("bad15_err", 32'(bus.prog_err), 32'h1);
        step("bad_end");
        check("bad_end_err", 32'(bus.prog_err), 32'h0);
        bus.load_en = 1'b0;
        step("oor_run");
        fetch(2, "alias2");
        check("alias2_val", bus.fetch_data, NOP);

        // Mode switch: a fetch in the load_en cycle is lost.
        bus.load_en    = 1'b1;
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 4'd0;
        step("msw");
        check("msw_vld", 32'(bus.fetch_valid), 32'h0);
        check("msw_rdy", 32'(bus.mem_ready), 32'h0);
        bus.load_en   = 1'b0;
        bus.fetch_req = 1'b0;
        step("msw_back");

        // Reset mid-LOAD wipes the memory again.
        bus.load_en = 1'b1;
        step("rml_enter");
        prog(3, 32'hDEAD_BEEF, "rml_w3");
        idle_inputs();
        rst_n = 1'b0;
        step("rml_rst");
        rst_n = 1'b1;
        repeat (DEPTH) step("rml_clr");
        fetch(3, "rml_f3");
        check("rml_f3_val", bus.fetch_data, NOP);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n          = ($urandom_range(399) != 0);
            if ($urandom_range(11) == 0) bus.load_en = ~bus.load_en;
            bus.prog_we    = $urandom_range(1) == 1;
            bus.prog_addr  = ADDR_W'($urandom_range(15));
            bus.prog_data  = $urandom;
            bus.fetch_req  = $urandom_range(3) != 0;
            bus.fetch_addr = ADDR_W'($urandom_range(15));
            bus.stall      = $urandom_range(3) == 0;
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
